// File: rtl/mac_pipe.sv
// rtl/mac_pipe.sv - three-stage unsigned multiply-add/accumulate pipeline with saturation
// Stage 1 registers operands, stage 2 the product, stage 3 the clipped result and accumulator.
module mac_pipe #(
  parameter int SIZE_A        = 8,
  parameter int SIZE_B        = 8,
  parameter int SIZE_C        = 8,
  parameter int SIZE_DATA_OUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SIZE_A-1:0]        A,
  input  logic [SIZE_B-1:0]        B,
  input  logic [SIZE_C-1:0]        C,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE_DATA_OUT-1:0] DATA_OUT,
  output logic                     out_sat
);

  localparam int SP = SIZE_A + SIZE_B;
  localparam int SW = SIZE_DATA_OUT + 1;
  localparam logic [1:0] MODE_ACC_START = 2'b01;
  localparam logic [1:0] MODE_ACC       = 2'b10;

  logic adv;

  logic              v1;
  logic [SIZE_A-1:0] a1;
  logic [SIZE_B-1:0] b1;
  logic [SIZE_C-1:0] c1;
  logic [1:0]        mode1;

  logic              v2;
  logic [SP-1:0]     p2;
  logic [SIZE_C-1:0] c2;
  logic [1:0]        mode2;

  logic [SIZE_DATA_OUT-1:0] acc;
  logic                     acc_sat;

  logic [SW-1:0]            base;
  logic [SW-1:0]            sum;
  logic                     clip;
  logic [SIZE_DATA_OUT-1:0] res;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // A saturated run stays pinned at all-ones even if later products are zero.
  always_comb begin
    base = (mode2 == MODE_ACC) ? {1'b0, acc} : SW'(c2);
    sum  = base + SW'(p2);
    clip = sum[SIZE_DATA_OUT] || ((mode2 == MODE_ACC) && acc_sat);
    res  = clip ? '1 : sum[SIZE_DATA_OUT-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      c1        <= '0;
      mode1     <= '0;
      v2        <= 1'b0;
      p2        <= '0;
      c2        <= '0;
      mode2     <= '0;
      out_valid <= 1'b0;
      DATA_OUT  <= '0;
      out_sat   <= 1'b0;
      acc       <= '0;
      acc_sat   <= 1'b0;
    end else if (adv) begin
      v1        <= in_valid;
      a1        <= A;
      b1        <= B;
      c1        <= C;
      mode1     <= mode;
      v2        <= v1;
      p2        <= SP'(a1) * SP'(b1);
      c2        <= c1;
      mode2     <= mode1;
      out_valid <= v2;
      if (v2) begin
        DATA_OUT <= res;
        out_sat  <= clip;
        if (mode2 == MODE_ACC_START || mode2 == MODE_ACC) begin
          acc     <= res;
          acc_sat <= clip;
        end
      end
    end
  end

endmodule
